// File: rtl/booth_prod_accumulator_if.sv
// Stream and status bundle between the Booth product source and the frame accumulator.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface booth_prod_accumulator_if #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 12
) ();
    logic              clear;
    logic              in_valid;
    logic [PROD_W-1:0] in_prod;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic [3:0]        beat_cnt;
    logic [7:0]        frames_done;

    modport master (
        output clear, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, beat_cnt, frames_done
    );

    modport slave (
        input  clear, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, beat_cnt, frames_done
    );
endinterface

// File: rtl/booth_prod_accumulator.sv
// Sums FRAME_LEN sign-extended Booth products into one frame result and tracks signed overflow.
// The result sits in a one-entry valid/ready register; only the closing beat waits on it.
module booth_prod_accumulator #(
    parameter int unsigned PROD_W    = 8,
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned FRAME_LEN = 4
) (
    input logic                     clk,
    input logic                     rst,
    booth_prod_accumulator_if.slave bus
);
    localparam logic [3:0] LastCnt = 4'(FRAME_LEN - 1);

    typedef enum logic {StAccum, StStall} state_e;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;
    logic [7:0]       frames_done_q, frames_done_d;

    state_e           state;
    logic             last;
    logic             in_ready;
    logic             beat;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             beat_ovf;

    assign last  = (beat_cnt_q == LastCnt);
    // Release from stall is combinational on out_ready so a drained result frees the slot at once.
    assign state = (last && out_valid_q && !bus.out_ready) ? StStall : StAccum;

    assign in_ready = !rst && !bus.clear && (state == StAccum);
    assign beat     = bus.in_valid && in_ready;

    assign prod_ext = {{(ACC_W - PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};
    assign sum      = acc_q + prod_ext;
    assign beat_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        acc_d         = acc_q;
        beat_cnt_d    = beat_cnt_q;
        ovf_acc_d     = ovf_acc_q;
        out_valid_d   = out_valid_q;
        out_sum_d     = out_sum_q;
        out_ovf_d     = out_ovf_q;
        frames_done_d = frames_done_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (bus.clear) begin
            acc_d      = '0;
            beat_cnt_d = '0;
            ovf_acc_d  = 1'b0;
        end else if (beat) begin
            if (last) begin
                // A closing beat overrides a same-edge drain, giving back-to-back frames.
                out_sum_d     = sum;
                out_ovf_d     = ovf_acc_q | beat_ovf;
                out_valid_d   = 1'b1;
                acc_d         = '0;
                beat_cnt_d    = '0;
                ovf_acc_d     = 1'b0;
                frames_done_d = frames_done_q + 8'd1;
            end else begin
                acc_d      = sum;
                beat_cnt_d = beat_cnt_q + 4'd1;
                ovf_acc_d  = ovf_acc_q | beat_ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q         <= '0;
            beat_cnt_q    <= '0;
            ovf_acc_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sum_q     <= '0;
            out_ovf_q     <= 1'b0;
            frames_done_q <= '0;
        end else begin
            acc_q         <= acc_d;
            beat_cnt_q    <= beat_cnt_d;
            ovf_acc_q     <= ovf_acc_d;
            out_valid_q   <= out_valid_d;
            out_sum_q     <= out_sum_d;
            out_ovf_q     <= out_ovf_d;
            frames_done_q <= frames_done_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sum     = out_sum_q;
    assign bus.out_ovf     = out_ovf_q;
    assign bus.beat_cnt    = beat_cnt_q;
    assign bus.frames_done = frames_done_q;
endmodule

// File: tb/tb_booth_prod_accumulator.sv
// Directed bench: instance A (ACC_W=12, FRAME_LEN=4) and instance B (ACC_W=10, FRAME_LEN=5).
// Inputs change 1ns after the rising edge; outputs are sampled there as well.
module tb_booth_prod_accumulator;
    logic clk;
    logic rst;

    int n_total;
    int n_pass;

    booth_prod_accumulator_if #(.PROD_W(8), .ACC_W(12)) ia ();
    booth_prod_accumulator_if #(.PROD_W(8), .ACC_W(10)) ib ();

    booth_prod_accumulator #(.PROD_W(8), .ACC_W(12), .FRAME_LEN(4)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    booth_prod_accumulator #(.PROD_W(8), .ACC_W(10), .FRAME_LEN(5)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic beat_a(input int p);
        ia.in_valid = 1'b1;
        ia.in_prod  = 8'(p);
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0;
    endtask

    task automatic beat_b(input int p);
        ib.in_valid = 1'b1;
        ib.in_prod  = 8'(p);
        @(posedge clk);
        #1;
        ib.in_valid = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        ia.clear = 1'b0; ia.in_valid = 1'b0; ia.in_prod = '0; ia.out_ready = 1'b1;
        ib.clear = 1'b0; ib.in_valid = 1'b0; ib.in_prod = '0; ib.out_ready = 1'b1;

        // Reset / defaults
        #3;
        check_eq("in_ready_in_rst", 32'(ia.in_ready), 32'd0);
        #19 rst = 1'b0;
        tick();
        check_eq("rst_in_ready", 32'(ia.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(ia.out_valid), 32'd0);
        check_eq("rst_out_sum", 32'(ia.out_sum), 32'd0);
        check_eq("rst_out_ovf", 32'(ia.out_ovf), 32'd0);
        check_eq("rst_beat_cnt", 32'(ia.beat_cnt), 32'd0);
        check_eq("rst_frames_done", 32'(ia.frames_done), 32'd0);

        // Overflow on B: 5 x 127 = 635 wraps to -389 in 10 bits
        for (int i = 0; i < 5; i++) beat_b(127);
        check_eq("ovf_out_valid", 32'(ib.out_valid), 32'd1);
        check_eq("ovf_out_sum", 32'(ib.out_sum), 32'h27B);
        check_eq("ovf_flag", 32'(ib.out_ovf), 32'd1);
        for (int i = 0; i < 5; i++) beat_b(-100);
        check_eq("noovf_out_sum", 32'(ib.out_sum), 32'h20C);
        check_eq("noovf_flag", 32'(ib.out_ovf), 32'd0);
        check_eq("noovf_frames", 32'(ib.frames_done), 32'd2);

        // Signed sum on A: 6 - 12 + 15 - 1 = 8
        beat_a(6);
        beat_a(-12);
        check_eq("sum_mid_beat_cnt", 32'(ia.beat_cnt), 32'd2);
        beat_a(15);
        beat_a(-1);
        ia.out_ready = 1'b0;
        check_eq("sum_out_valid", 32'(ia.out_valid), 32'd1);
        check_eq("sum_out_sum", 32'(ia.out_sum), 32'h008);
        check_eq("sum_out_ovf", 32'(ia.out_ovf), 32'd0);
        check_eq("sum_frames", 32'(ia.frames_done), 32'd1);
        check_eq("sum_beat_cnt", 32'(ia.beat_cnt), 32'd0);

        // Backpressure: intermediate beats flow, closing beat stalls
        for (int i = 0; i < 3; i++) beat_a(10);
        check_eq("bp_beat_cnt", 32'(ia.beat_cnt), 32'd3);
        ia.in_valid = 1'b1;
        ia.in_prod  = 8'd10;
        #1;
        check_eq("bp_in_ready_low", 32'(ia.in_ready), 32'd0);
        tick();
        check_eq("bp_held_sum", 32'(ia.out_sum), 32'h008);
        check_eq("bp_held_valid", 32'(ia.out_valid), 32'd1);
        check_eq("bp_held_cnt", 32'(ia.beat_cnt), 32'd3);
        ia.out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(ia.in_ready), 32'd1);
        tick();
        ia.in_valid = 1'b0;
        check_eq("bp_no_bubble_valid", 32'(ia.out_valid), 32'd1);
        check_eq("bp_sum40", 32'(ia.out_sum), 32'h028);
        check_eq("bp_frames", 32'(ia.frames_done), 32'd2);
        tick();
        check_eq("bp_drained", 32'(ia.out_valid), 32'd0);

        // Idle input with X product must not disturb state
        ia.in_prod = 'x;
        tick();
        check_eq("x_idle_cnt", 32'(ia.beat_cnt), 32'd0);
        check_eq("x_idle_sum", 32'(ia.out_sum), 32'h028);

        // Clear mid-frame
        beat_a(50);
        beat_a(50);
        check_eq("clr_pre_cnt", 32'(ia.beat_cnt), 32'd2);
        ia.clear = 1'b1;
        #1;
        check_eq("clr_in_ready", 32'(ia.in_ready), 32'd0);
        tick();
        ia.clear = 1'b0;
        check_eq("clr_cnt_zero", 32'(ia.beat_cnt), 32'd0);
        check_eq("clr_frames_kept", 32'(ia.frames_done), 32'd2);
        beat_a(1);
        beat_a(2);
        beat_a(3);
        beat_a(4);
        ia.out_ready = 1'b0;
        check_eq("clr_sum10", 32'(ia.out_sum), 32'h00A);
        check_eq("clr_frames", 32'(ia.frames_done), 32'd3);

        // Async reset while stalled
        for (int i = 0; i < 3; i++) beat_a(1);
        ia.in_valid = 1'b1;
        ia.in_prod  = 8'd1;
        #1;
        check_eq("stall_in_ready", 32'(ia.in_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(ia.out_valid), 32'd0);
        check_eq("arst_beat_cnt", 32'(ia.beat_cnt), 32'd0);
        check_eq("arst_frames", 32'(ia.frames_done), 32'd0);
        ia.in_valid = 1'b0;
        #2 rst = 1'b0;
        tick();
        check_eq("arst_in_ready", 32'(ia.in_ready), 32'd1);
        ia.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat_a(1);
        check_eq("arst_sum4", 32'(ia.out_sum), 32'h004);
        check_eq("arst_valid", 32'(ia.out_valid), 32'd1);
        check_eq("arst_frames1", 32'(ia.frames_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/booth_prod_accumulator.md
Name: booth_prod_accumulator

Overview:
- Downstream consumer of the 4x4 Booth multiplier's 8-bit product.
- Sign-extends each product and sums FRAME_LEN consecutive products into one dot-product result.
- Presents the result through a one-entry valid/ready output register.
- Turns the combinational multiplier into a streaming MAC stage.

Parameters:
- PROD_W, 8: width of incoming product; two's-complement signed.
- ACC_W, 12: accumulator and result width; must be >= PROD_W+1.
- FRAME_LEN, 4: products per frame; legal range 2..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous frame abort; discards the partial frame.
- in_valid  in  1  product present on in_prod.
- in_prod  in  PROD_W  signed product from the multiplier.
- in_ready  out  1  stage can accept in_prod this cycle.
- out_valid  out  1  out_sum / out_ovf hold a completed frame.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  signed frame sum.
- out_ovf  out  1  signed overflow occurred somewhere in this frame.
- beat_cnt  out  4  products accepted so far in the current frame.
- frames_done  out  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset (async, immediate): acc=0, beat_cnt=0, ovf_acc=0, out_valid=0, out_sum=0, out_ovf=0, frames_done=0.
- While rst is high, in_ready=0.
- Beat = in_valid & in_ready. Internal last = (beat_cnt == FRAME_LEN-1).
- in_ready (combinational) = !rst & !clear & !(last & out_valid & !out_ready).
  - Intermediate beats are never stalled by a pending output.
  - Only the closing beat waits for the output register to free up.
- Arithmetic:
  - sum = acc + sign_extend(in_prod) to ACC_W, wrapping modulo 2^ACC_W.
  - Overflow: both operands have the same sign and the sum sign differs.
  - ovf_acc becomes sticky-OR of the overflow of each beat.
- Non-last beat: acc<=sum; beat_cnt<=beat_cnt+1; ovf_acc updated.
- Last beat, on the same edge:
  - out_sum<=sum; out_ovf<=ovf_acc|this-beat overflow; out_valid<=1.
  - acc<=0; beat_cnt<=0; ovf_acc<=0; frames_done<=frames_done+1.
  - Latency: result visible the cycle after the closing beat.
- Output handshake:
  - out_valid & out_ready clears out_valid next cycle unless a new last beat loads that same edge; the load wins and out_valid stays 1.
  - Gives back-to-back frames with no bubble.
  - out_sum/out_ovf are held stable while out_valid & !out_ready.
- Two-state view:
  - ACCUM: normal operation.
  - STALL: last-pending, out_valid=1, out_ready=0; in_ready=0.
  - STALL -> ACCUM as soon as out_ready=1 (combinational release).
- clear=1:
  - in_ready=0; acc, beat_cnt, ovf_acc zeroed next edge.
  - out_valid/out_sum/out_ovf/frames_done untouched; a pending result is still delivered.
  - An output handshake in the same cycle is still honoured.
- in_prod is ignored when in_valid=0. X on in_prod without in_valid must not corrupt state.
- Reset mid-frame or mid-stall discards everything; in_ready rises the first cycle after rst falls.

Test Plan:
- Reset / defaults: assert rst, then release; out_ready=1 -> all outputs 0, in_ready=1 the cycle after release.
- Signed sum: FRAME_LEN=4, products 6, -12, 15, -1 back-to-back -> one cycle after 4th beat, out_valid=1, out_sum=8 (0x008), out_ovf=0, frames_done=1, beat_cnt=0.
- Backpressure:
  - Hold out_ready=0 after frame 1.
  - Feed 4 more products of 10: first 3 accepted, beat_cnt=3, 4th sees in_ready=0 and out_sum stays 8.
  - Raise out_ready for one cycle -> 4th beat accepted that cycle and out_sum=40 next cycle with no bubble.
- Overflow: ACC_W=10, FRAME_LEN=5, five products of 127 -> out_sum = 635-1024 = -389 (0x27B), out_ovf=1.
  - Next frame of 5x -100 = -500 -> out_ovf=0 (sticky flag cleared per frame).
- Clear mid-frame: two beats (50, 50), then clear for one cycle (in_ready=0), then products 1,2,3,4 -> out_sum=10; frames_done increments by exactly 1.
- Async reset mid-stall: in STALL state pulse rst between clock edges -> out_valid drops immediately, beat_cnt=0; a subsequent frame 1,1,1,1 yields out_sum=4.
